// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 instruction fetch path.
package ysyx_24100005_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [7:0]  IFU_TIMEOUT  = 8'd255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StHold = 2'd3
    } ifu_state_e;

    // Contents of the inst/err output buffer.
    typedef struct packed {
        logic        err;
        logic [31:0] inst;
    } fetch_buf_t;

    // Instructions must be word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Generic register with write enable and asynchronous active-high reset.
module ysyx_24100005_Reg #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load din when enabled, otherwise hold.
    always_comb begin
        data_d = wen ? din : data_q;
    end

    // Storage flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: issues one read per fetch request on an AXI-lite style
// read channel and holds the result until the core consumes it.
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [7:0]  TIMEOUT  = IFU_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready
);

    ifu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;

    fetch_buf_t  buf_din;
    fetch_buf_t  buf_dout;
    logic        buf_wen;

    // State, latched address and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= RESET_PC;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, including result buffer loads.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        buf_wen = 1'b0;
        buf_din = '{err: 1'b0, inst: 32'h0};
        unique case (state_q)
            StIdle, StHold: begin
                // HOLD behaves like IDLE once the core takes the result.
                if (state_q == StIdle || inst_ready) begin
                    if (!fetch_req) begin
                        state_d = StIdle;
                    end else if (is_aligned(pc)) begin
                        state_d = StAddr;
                        addr_d  = pc;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = StHold;
                        buf_wen = 1'b1;
                        buf_din = '{err: 1'b1, inst: 32'h0};
                    end
                end
            end
            StAddr: begin
                // Handshake wins over timeout.
                if (mem_arready) begin
                    state_d = StData;
                end else if (cnt_q == TIMEOUT) begin
                    state_d = StHold;
                    buf_wen = 1'b1;
                    buf_din = '{err: 1'b1, inst: 32'h0};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StData: begin
                if (mem_rvalid) begin
                    state_d = StHold;
                    buf_wen = 1'b1;
                    buf_din = '{err: (mem_rresp != 2'b00), inst: mem_rdata};
                end else if (cnt_q == TIMEOUT) begin
                    state_d = StHold;
                    buf_wen = 1'b1;
                    buf_din = '{err: 1'b1, inst: 32'h0};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        mem_arvalid = (state_q == StAddr);
        mem_rready  = (state_q == StData);
        mem_araddr  = addr_q;
        inst_valid  = (state_q == StHold);
        inst        = buf_dout.inst;
        fetch_err   = buf_dout.err & (state_q == StHold);
    end

    ysyx_24100005_Reg #(
        .WIDTH     ($bits(fetch_buf_t)),
        .RESET_VAL ('0)
    ) u_inst_buf (
        .clk  (clk),
        .rst  (rst),
        .din  (buf_din),
        .dout (buf_dout),
        .wen  (buf_wen)
    );

endmodule

// File: doc/ysyx_24100005_ifu.md
YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, giving the reset value of the latched fetch address.
REQ-002 The block SHALL have parameter TIMEOUT, default 8'd255, giving the maximum number of wait cycles per fetch before an error is raised.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port pc, input, 32 bits: fetch address driven by the core PC register.
REQ-006 The block SHALL have port fetch_req, input, 1 bit: core requests a fetch of pc.
REQ-007 The block SHALL have port inst, output, 32 bits: fetched instruction word.
REQ-008 The block SHALL have port inst_valid, output, 1 bit: inst and fetch_err are valid.
REQ-009 The block SHALL have port inst_ready, input, 1 bit: core consumes inst this cycle.
REQ-010 The block SHALL have port fetch_err, output, 1 bit: misaligned pc, bus error or timeout.
REQ-011 The block SHALL have ports mem_arvalid (out, 1), mem_araddr (out, 32) and mem_arready (in, 1): the read-address channel.
REQ-012 The block SHALL have ports mem_rvalid (in, 1), mem_rdata (in, 32), mem_rresp (in, 2) and mem_rready (out, 1): the read-data channel.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ADDR, DATA and HOLD.
REQ-014 In IDLE with fetch_req=1 and pc[1:0]=0, the block SHALL latch pc into addr_q, clear the wait counter and go to ADDR.
REQ-015 In IDLE with fetch_req=1 and pc[1:0]!=0, the block SHALL load inst=0 and err=1, go to HOLD, and issue no bus access.
REQ-016 In ADDR, mem_arvalid SHALL be 1 and mem_araddr SHALL equal addr_q, both held stable until mem_arready=1; the handshake SHALL move the FSM to DATA.
REQ-017 In DATA, mem_rready SHALL be 1; on mem_rvalid=1 the block SHALL capture mem_rdata into inst, set err=(mem_rresp!=0) and go to HOLD.
REQ-018 In HOLD, inst_valid SHALL be 1 and inst/fetch_err SHALL be stable until inst_ready=1.
REQ-019 On HOLD with inst_ready=1 and fetch_req=1 in the same cycle, the block SHALL apply the IDLE decision of REQ-014/REQ-015 directly, giving back-to-back fetches; with inst_ready=1 and fetch_req=0 it SHALL go to IDLE.
REQ-020 fetch_req SHALL be ignored in ADDR and DATA; pc changes there SHALL NOT affect mem_araddr.
REQ-021 An 8-bit wait counter SHALL increment every cycle in ADDR or DATA without a completing handshake.
REQ-022 When the wait counter equals TIMEOUT, the block SHALL go to HOLD with inst=0 and fetch_err=1, deasserting mem_arvalid/mem_rready in that same next cycle.
REQ-023 A completing handshake SHALL take priority over timeout in the same cycle.
REQ-024 Minimum latency SHALL be: fetch_req at cycle 0, mem_arvalid at cycle 1, mem_rvalid accepted at cycle 2, inst_valid at cycle 3.
REQ-025 mem_arvalid and mem_rready SHALL never be 1 simultaneously.

Reset
REQ-026 On rst=1 the block SHALL immediately, without waiting for a clock edge, force state=IDLE, addr_q=RESET_PC, inst=0, err=0 and wait counter=0.
REQ-027 During and after reset, outputs SHALL be inst_valid=0, fetch_err=0, mem_arvalid=0, mem_rready=0 and mem_araddr=RESET_PC.
REQ-028 A reset asserted mid-fetch SHALL abandon the transaction; a later mem_rvalid SHALL be ignored because mem_rready=0.

Structure
REQ-029 The state encodings, RESET_PC default and TIMEOUT default SHALL live in the shared ysyx_24100005 package/header.
REQ-030 The inst/err output buffer SHALL be an instance of the existing ysyx_24100005_Reg; no other sub-module is required.

Verification
REQ-031 Bench SHALL check: pc=8000_0000 with fetch_req, arready and rvalid immediate, rdata=0010_0073 -> inst_valid at cycle 3 with inst=0010_0073, fetch_err=0.
REQ-032 Bench SHALL check: arready held low 5 cycles while pc changes to 8000_0010 -> mem_araddr stays 8000_0000, then inst delivered normally.
REQ-033 Bench SHALL check: pc=8000_0002 -> no mem_arvalid, inst_valid next cycle with inst=0 and fetch_err=1.
REQ-034 Bench SHALL check: rresp=2'b10 -> fetch_err=1; memory never answering -> fetch_err=1 after 255 wait cycles.
REQ-035 Bench SHALL check: inst_ready held low 4 cycles, then inst_ready=1 together with fetch_req at pc=8000_0004 -> inst held stable, and mem_arvalid for 8000_0004 on the next cycle.
REQ-036 Bench SHALL check: rst asserted in DATA, then rvalid pulsed -> outputs at reset values immediately, pulse ignored, next fetch correct.
